riscv_boot_loader: RTL and testbench
====================================

RISCV_BOOT_LOADER -- requirements
Module: riscv_boot_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of instruction memory; DEPTH = 2**ADDR_W words.
REQ-002 Parameter HOLD_CYCLES, default 4, number of cycles core stays in reset after the last word is written; legal range 1..255.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 rx_valid  input  1  byte available on rx_data.
REQ-006 rx_data  input  8  boot stream byte.
REQ-007 rx_ready  output  1  loader accepts byte; a transfer occurs when rx_valid and rx_ready are both high at a rising clk edge.
REQ-008 imem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of the write.
REQ-010 imem_wdata  output  32  instruction word.
REQ-011 core_reset_n  output  1  active-low reset to riscv_pipeline_top.
REQ-012 boot_done  output  1  high when the core has been released.
REQ-013 boot_err  output  1  high when the header word count exceeds DEPTH.

Function
REQ-014 Stream format: 2-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte goes to imem_wdata[7:0]).
REQ-015 FSM states: HDR0, HDR1, LOAD, HOLD, RUN, ERR; HDR0 is entered from reset.
REQ-016 HDR0: accept 1 byte into N[7:0], then go to HDR1.
REQ-017 HDR1: accept 1 byte into N[15:8], then branch on N. N = 0 goes to HOLD. N > DEPTH goes to ERR. Otherwise go to LOAD.
REQ-018 LOAD: 2-bit byte counter assembles the word. On the transfer of byte 3, the next cycle has imem_we = 1, imem_addr = current word index and imem_wdata = the assembled word.
REQ-019 The word index starts at 0 and increments by 1 after each write. When the written index equals N-1, go to HOLD.
REQ-020 The word index never wraps, because N <= DEPTH is guaranteed by REQ-017. N = DEPTH writes addresses 0..DEPTH-1 exactly once.
REQ-021 rx_ready = 1 in HDR0, HDR1 and LOAD, except during the imem_we cycle, when rx_ready = 0 (one-cycle bubble per word). rx_ready = 0 in HOLD, RUN and ERR.
REQ-022 rx_valid with rx_ready = 0 is ignored, with no data loss requirement on the source beyond holding the byte.
REQ-023 HOLD: count HOLD_CYCLES cycles with core_reset_n = 0, then go to RUN.
REQ-024 RUN: core_reset_n = 1 and boot_done = 1. RUN is terminal until reset.
REQ-025 ERR: boot_err = 1, core_reset_n = 0 and boot_done = 0. ERR is terminal until reset.
REQ-026 core_reset_n, boot_done, boot_err and imem_we are registered outputs, glitch-free.
REQ-027 imem_we is never high outside LOAD and is never high for two consecutive cycles.

Reset
REQ-028 Asserting reset_n low, at any time including mid-word or during HOLD, immediately forces: state HDR0, core_reset_n = 0, boot_done = 0, boot_err = 0, imem_we = 0, rx_ready = 0, imem_addr = 0, imem_wdata = 0, all counters 0.
REQ-029 Any partially assembled word is discarded on reset.
REQ-030 rx_ready rises in the first cycle after reset_n is deasserted.

Verification
REQ-031 Stream 02 00, 13 00 00 00, 93 00 10 00 -> writes addr0 = 0x00000013 and addr1 = 0x00100093; core_reset_n rises exactly HOLD_CYCLES cycles after the second write; boot_done = 1.
REQ-032 Stream 00 00 -> no imem_we; core_reset_n rises HOLD_CYCLES cycles after the header is accepted.
REQ-033 N = 256 with ADDR_W = 8 -> 256 writes to addresses 0..255 in order, then release. N = 257 -> boot_err = 1, no imem_we, core_reset_n stays 0 and rx_ready = 0.
REQ-034 rx_valid toggled randomly, including held high during the write bubble -> assembled words are identical to the byte-exact expected words, and no byte is consumed while rx_ready = 0.
REQ-035 reset_n pulsed low after 2 bytes of word 1, then the full stream is replayed -> all outputs reach their reset values asynchronously, the replayed stream loads correctly, and no stale bytes appear.
REQ-036 After RUN, continued rx_valid traffic -> rx_ready = 0, no imem_we, and core_reset_n stays 1.

Source files
------------

// File: rtl/riscv_boot_loader.sv
// Boot loader: receives a byte stream (16-bit word count + little-endian words),
// writes instruction memory, then holds the core in reset before releasing it.
module riscv_boot_loader #(
    parameter int ADDR_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset_n,
    output logic              boot_done,
    output logic              boot_err
);

    localparam logic [16:0] DEPTH_EXT = 17'(1) << ADDR_W;
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [7:0]        r_n_lo;
    logic [ADDR_W-1:0] r_last_idx;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;
    logic [7:0]        r_hold_cnt;
    logic              r_rx_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_rst_n;
    logic              r_boot_done;
    logic              r_boot_err;

    logic [7:0]        w_n_lo_next;
    logic [ADDR_W-1:0] w_last_idx_next;
    logic [ADDR_W-1:0] w_idx_next;
    logic [1:0]        w_byte_cnt_next;
    logic [23:0]       w_word_next;
    logic [7:0]        w_hold_cnt_next;
    logic              w_we_next;
    logic [ADDR_W-1:0] w_addr_next;
    logic [31:0]       w_wdata_next;
    logic              w_rx_ready_next;

    logic              w_xfer;
    logic [16:0]       w_n_ext;

    assign w_xfer  = rx_valid & r_rx_ready;
    assign w_n_ext = {1'b0, rx_data, r_n_lo};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_HDR0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_n_lo_next     = r_n_lo;
        w_last_idx_next = r_last_idx;
        w_idx_next      = r_idx;
        w_byte_cnt_next = r_byte_cnt;
        w_word_next     = r_word;
        w_hold_cnt_next = r_hold_cnt;
        w_we_next       = 1'b0;
        w_addr_next     = r_imem_addr;
        w_wdata_next    = r_imem_wdata;

        case (r_state)
            S_HDR0: begin
                if (w_xfer) begin
                    w_n_lo_next  = rx_data;
                    w_state_next = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_xfer) begin
                    if (w_n_ext == 17'd0) begin
                        w_state_next = S_HOLD;
                    end else if (w_n_ext > DEPTH_EXT) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next    = S_LOAD;
                        w_last_idx_next = ADDR_W'(w_n_ext - 17'd1);
                        w_idx_next      = '0;
                    end
                end
            end
            S_LOAD: begin
                // The write cycle doubles as the bubble: no byte can arrive in it.
                if (r_imem_we) begin
                    if (r_idx == r_last_idx) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end else if (w_xfer) begin
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    case (r_byte_cnt)
                        2'd0:    w_word_next[7:0]   = rx_data;
                        2'd1:    w_word_next[15:8]  = rx_data;
                        2'd2:    w_word_next[23:16] = rx_data;
                        default: begin
                            w_we_next    = 1'b1;
                            w_addr_next  = r_idx;
                            w_wdata_next = {rx_data, r_word};
                        end
                    endcase
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_next = S_RUN;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 8'd1;
                end
            end
            S_RUN:   w_state_next = S_RUN;
            S_ERR:   w_state_next = S_ERR;
            default: w_state_next = S_HDR0;
        endcase

        w_rx_ready_next = ((w_state_next == S_HDR0) || (w_state_next == S_HDR1) ||
                           (w_state_next == S_LOAD)) && !w_we_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n_lo       <= '0;
            r_last_idx   <= '0;
            r_idx        <= '0;
            r_byte_cnt   <= '0;
            r_word       <= '0;
            r_hold_cnt   <= '0;
            r_rx_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_core_rst_n <= 1'b0;
            r_boot_done  <= 1'b0;
            r_boot_err   <= 1'b0;
        end else begin
            r_n_lo       <= w_n_lo_next;
            r_last_idx   <= w_last_idx_next;
            r_idx        <= w_idx_next;
            r_byte_cnt   <= w_byte_cnt_next;
            r_word       <= w_word_next;
            r_hold_cnt   <= w_hold_cnt_next;
            r_rx_ready   <= w_rx_ready_next;
            r_imem_we    <= w_we_next;
            r_imem_addr  <= w_addr_next;
            r_imem_wdata <= w_wdata_next;
            r_core_rst_n <= (w_state_next == S_RUN);
            r_boot_done  <= (w_state_next == S_RUN);
            r_boot_err   <= (w_state_next == S_ERR);
        end
    end

    assign rx_ready     = r_rx_ready;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign core_reset_n = r_core_rst_n;
    assign boot_done    = r_boot_done;
    assign boot_err     = r_boot_err;

endmodule

// File: tb/tb_riscv_boot_loader.sv
// Self-checking bench for riscv_boot_loader: table of boot streams, a byte-level
// reference model of the expected writes and release timing, plus reset corner cases.
module tb_riscv_boot_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int HOLD   = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_reset_n;
    logic              boot_done;
    logic              boot_err;

    riscv_boot_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_reset_n (core_reset_n),
        .boot_done    (boot_done),
        .boot_err     (boot_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        bit rnd;
        bit fixed;
        bit exp_err;
        int exp_we;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Monitor-owned observation state (written only by the monitor).
    int cyc = 0;
    int xfer_total = 0;
    int last_xfer_cyc = 0;
    int we_total = 0;
    int last_we_cyc = 0;
    int consec_cnt = 0;
    int bubble_cnt = 0;
    int run_ready_cnt = 0;
    int rise_cyc = -1;
    bit prev_we = 1'b0;
    bit prev_crn = 1'b0;
    logic [ADDR_W-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];

    // Stimulus and reference model state.
    logic [7:0]        stream_q[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int m_n;
    bit aborted;
    int b_xfer, b_we, b_obs, b_cyc, b_consec, b_bubble, b_run;

    always @(negedge clk) begin
        cyc++;
        if (rx_valid && rx_ready) begin
            xfer_total++;
            last_xfer_cyc = cyc;
        end
        if (imem_we) begin
            we_total++;
            last_we_cyc = cyc;
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
            if (prev_we) consec_cnt++;
            if (rx_ready) bubble_cnt++;
        end
        if (core_reset_n && !prev_crn) rise_cyc = cyc;
        if (core_reset_n && rx_ready) run_ready_cnt++;
        prev_we  = imem_we;
        prev_crn = core_reset_n;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build(input vec_t v);
        logic [15:0] nn;
        nn = 16'(v.n);
        stream_q.delete();
        stream_q.push_back(nn[7:0]);
        stream_q.push_back(nn[15:8]);
        if (v.fixed) begin
            stream_q.push_back(8'h13); stream_q.push_back(8'h00);
            stream_q.push_back(8'h00); stream_q.push_back(8'h00);
            stream_q.push_back(8'h93); stream_q.push_back(8'h00);
            stream_q.push_back(8'h10); stream_q.push_back(8'h00);
        end else if (v.n <= DEPTH) begin
            for (int i = 0; i < 4 * v.n; i++) stream_q.push_back(8'($urandom));
        end
    endtask

    // Reference: header gives N; word i is bytes 2+4i..5+4i, first byte lowest.
    task automatic model_setup();
        m_n = int'({stream_q[1], stream_q[0]});
        exp_addr.delete();
        exp_data.delete();
        if (m_n <= DEPTH) begin
            for (int i = 0; i < m_n; i++) begin
                exp_addr.push_back(ADDR_W'(i));
                exp_data.push_back({stream_q[4*i+5], stream_q[4*i+4],
                                    stream_q[4*i+3], stream_q[4*i+2]});
            end
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2 reset_n = 1'b0;
        #1 chk("reset_outputs", 64'({rx_ready, imem_we, core_reset_n, boot_done, boot_err,
                                     imem_addr, imem_wdata}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        model_setup();
        aborted  = 1'b0;
        b_xfer   = xfer_total;
        b_we     = we_total;
        b_obs    = obs_addr.size();
        b_cyc    = cyc;
        b_consec = consec_cnt;
        b_bubble = bubble_cnt;
        b_run    = run_ready_cnt;
        @(posedge clk);
        #1 chk("ready_after_reset", 64'(rx_ready), 64'(1));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        rx_data = b;
        while (!acc && guard < 300) begin
            rx_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            acc = rx_valid && rx_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            chk("byte_accepted", 64'(acc), 64'(1));
            aborted = 1'b1;
        end
    endtask

    task automatic send_all(input int cut, input bit rnd);
        for (int k = 0; k < stream_q.size() && (cut < 0 || k < cut) && !aborted; k++)
            send_byte(stream_q[k], rnd);
        rx_valid = 1'b0;
    endtask

    task automatic check_done(input vec_t v);
        int t_evt, nw, bx, bw;
        if (v.exp_err) begin
            rx_valid = 1'b1;
            rx_data  = 8'h5A;
            repeat (8) begin
                @(posedge clk);
                #1;
            end
            chk("err_ready", 64'(rx_ready), 64'(0));
            rx_valid = 1'b0;
            chk("boot_err", 64'(boot_err), 64'(1));
            chk("err_core_reset", 64'(core_reset_n), 64'(0));
            chk("err_done", 64'(boot_done), 64'(0));
            chk("err_writes", 64'(we_total - b_we), 64'(v.exp_we));
            chk("err_xfers", 64'(xfer_total - b_xfer), 64'(2));
        end else begin
            for (int w = 0; w < HOLD + 40 && !(rise_cyc > b_cyc); w++) begin
                @(posedge clk);
                #1;
            end
            chk("release_seen", 64'(rise_cyc > b_cyc), 64'(1));
            t_evt = (m_n == 0) ? last_xfer_cyc : last_we_cyc;
            chk("release_delay", 64'(rise_cyc - t_evt), 64'(HOLD + 1));
            chk("boot_done", 64'(boot_done), 64'(1));
            chk("boot_err_clear", 64'(boot_err), 64'(0));
            chk("write_count", 64'(we_total - b_we), 64'(v.exp_we));
            nw = obs_addr.size() - b_obs;
            if (nw > exp_addr.size()) nw = exp_addr.size();
            for (int i = 0; i < nw; i++) begin
                chk("write_addr", 64'(obs_addr[b_obs+i]), 64'(exp_addr[i]));
                chk("write_data", 64'(obs_data[b_obs+i]), 64'(exp_data[i]));
            end
            chk("xfer_count", 64'(xfer_total - b_xfer), 64'(2 + 4 * m_n));
            chk("consecutive_we", 64'(consec_cnt - b_consec), 64'(0));
            chk("ready_in_bubble", 64'(bubble_cnt - b_bubble), 64'(0));
            bx = xfer_total;
            bw = we_total;
            rx_valid = 1'b1;
            repeat (10) begin
                rx_data = 8'($urandom);
                @(posedge clk);
                #1;
            end
            rx_valid = 1'b0;
            chk("run_xfers", 64'(xfer_total - bx), 64'(0));
            chk("run_writes", 64'(we_total - bw), 64'(0));
            chk("run_core_reset", 64'(core_reset_n), 64'(1));
            chk("run_ready", 64'(run_ready_cnt - b_run), 64'(0));
        end
        $display("stream N=%0d rnd=%0b: writes=%0d err=%0b done=%0b core_reset_n=%0b",
                 v.n, v.rnd, we_total - b_we, boot_err, boot_done, core_reset_n);
    endtask

    vec_t tbl[8];
    vec_t v_mid;
    vec_t v_hold;

    initial begin
        tbl[0] = '{n: 2,     rnd: 0, fixed: 1, exp_err: 0, exp_we: 2};
        tbl[1] = '{n: 0,     rnd: 0, fixed: 0, exp_err: 0, exp_we: 0};
        tbl[2] = '{n: 256,   rnd: 0, fixed: 0, exp_err: 0, exp_we: 256};
        tbl[3] = '{n: 257,   rnd: 0, fixed: 0, exp_err: 1, exp_we: 0};
        tbl[4] = '{n: 7,     rnd: 1, fixed: 0, exp_err: 0, exp_we: 7};
        tbl[5] = '{n: 1,     rnd: 1, fixed: 0, exp_err: 0, exp_we: 1};
        tbl[6] = '{n: 65535, rnd: 1, fixed: 0, exp_err: 1, exp_we: 0};
        tbl[7] = '{n: 24,    rnd: 1, fixed: 0, exp_err: 0, exp_we: 24};
        v_mid  = '{n: 3,     rnd: 0, fixed: 0, exp_err: 0, exp_we: 3};
        v_hold = '{n: 1,     rnd: 1, fixed: 0, exp_err: 0, exp_we: 1};

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            build(tbl[i]);
            do_reset();
            send_all(-1, tbl[i].rnd);
            check_done(tbl[i]);
        end

        // Reset after two bytes of word 1, then replay the whole stream.
        build(v_mid);
        do_reset();
        send_all(8, 1'b0);
        #3 reset_n = 1'b0;
        #1 chk("async_reset_midword", 64'({rx_ready, imem_we, core_reset_n, boot_done,
                                           boot_err, imem_addr, imem_wdata}), 64'(0));
        do_reset();
        send_all(-1, 1'b0);
        check_done(v_mid);

        // Reset while the core is still being held, then replay.
        build(v_hold);
        do_reset();
        send_all(-1, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #3 reset_n = 1'b0;
        #1 chk("async_reset_hold", 64'({rx_ready, imem_we, core_reset_n, boot_done,
                                        boot_err, imem_addr, imem_wdata}), 64'(0));
        do_reset();
        send_all(-1, 1'b1);
        check_done(v_hold);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
